// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes with non-default immediate handling,
// the NOP instruction word and the hardwired-zero register index.
// No logic; imported by the IF/ID decode stage and its register file.
package mips_pkg;

    localparam logic [5:0]  OP_ANDI  = 6'h0C;
    localparam logic [5:0]  OP_ORI   = 6'h0D;
    localparam logic [5:0]  OP_XORI  = 6'h0E;
    localparam logic [5:0]  OP_LUI   = 6'h0F;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/if_id_decode_reg_file.sv
// Purpose: 2**REG_AW x DATA_W register file, two combinational read ports, one write port.
// Latency: reads are combinational, with the same-cycle WB write bypassed to both ports.
// Backpressure: none; a write lands on every clock edge where it is enabled.
// Ports: clk/reset, wr_en/wr_addr/wr_data (write-back), rd_addr_a/b -> rd_data_a/b.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int NREGS = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_live;

    // Register zero is never written, so it stays at its reset value of 0.
    assign wr_live = wr_en && (wr_addr != REG_AW'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Write-before-read: a write in flight this cycle is visible to the reader now.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        if (wr_live && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (wr_live && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
        if (rd_addr_a == REG_AW'(REG_ZERO))    rd_data_a = '0;
        if (rd_addr_b == REG_AW'(REG_ZERO))    rd_data_b = '0;
    end

endmodule

// File: rtl/if_id_decode.sv
// Purpose: IF/ID pipeline register plus register read, immediate/target decode and load-use hazard detect.
// Latency: IF_* captured in one cycle; all decode outputs are combinational from IF/ID and inputs.
// Backpressure: a load-use stall holds IF/ID and drops PCWrite for one cycle; ID_Flush overrides the stall.
// Ports: IF_* in from fetch, EX_* hazard inputs, WB_* write-back, ID_* / decode fields / PCWrite / IDEX_Bubble out.
module if_id_decode
    import mips_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          REG_AW = 5,
    parameter logic [31:0] NOP    = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       IF_Instruction,
    input  logic [31:0]       IF_PC,
    input  logic [31:0]       IF_PC_plus4,
    input  logic              ID_Flush,
    input  logic              EX_MemRead,
    input  logic [REG_AW-1:0] EX_Rt,
    input  logic              WB_RegWrite,
    input  logic [REG_AW-1:0] WB_WriteAddr,
    input  logic [DATA_W-1:0] WB_WriteData,
    output logic [31:0]       ID_Instruction,
    output logic [31:0]       ID_PC,
    output logic [31:0]       ID_PC_plus4,
    output logic [REG_AW-1:0] Rs_addr,
    output logic [REG_AW-1:0] Rt_addr,
    output logic [REG_AW-1:0] Rd_addr,
    output logic [4:0]        Shamt,
    output logic [DATA_W-1:0] Rs_data,
    output logic [DATA_W-1:0] Rt_data,
    output logic [31:0]       Imm_ext,
    output logic [31:0]       Branch_target,
    output logic [31:0]       Jump_target,
    output logic              PCWrite,
    output logic              IDEX_Bubble
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        stall;
    logic [15:0] imm;
    logic [31:0] imm_sext;

    // Hazard check: the load in ID/EX targets a source of the instruction in ID.
    assign stall = EX_MemRead && (EX_Rt != REG_AW'(REG_ZERO)) &&
                   ((EX_Rt == Rs_addr) || (EX_Rt == Rt_addr));

    assign PCWrite     = ~stall;
    assign IDEX_Bubble = stall;

    always_comb begin
        instr_d = IF_Instruction;
        pc_d    = IF_PC;
        pc4_d   = IF_PC_plus4;
        if (ID_Flush) begin
            instr_d = NOP;
            pc_d    = '0;
            pc4_d   = '0;
        end else if (stall) begin
            instr_d = instr_q;
            pc_d    = pc_q;
            pc4_d   = pc4_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP;
            pc_q    <= '0;
            pc4_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign ID_Instruction = instr_q;
    assign ID_PC          = pc_q;
    assign ID_PC_plus4    = pc4_q;

    assign Rs_addr = instr_q[25:21];
    assign Rt_addr = instr_q[20:16];
    assign Rd_addr = instr_q[15:11];
    assign Shamt   = instr_q[10:6];
    assign imm     = instr_q[15:0];

    assign imm_sext = {{16{imm[15]}}, imm};

    // Logical immediates zero-extend, lui shifts into the upper half, everything else sign-extends.
    always_comb begin
        case (instr_q[31:26])
            OP_ANDI, OP_ORI, OP_XORI: Imm_ext = {16'h0000, imm};
            OP_LUI:                   Imm_ext = {imm, 16'h0000};
            default:                  Imm_ext = imm_sext;
        endcase
    end

    // Modulo-2^32 add; wrap-around is architecturally allowed.
    assign Branch_target = pc4_q + {imm_sext[29:0], 2'b00};
    assign Jump_target   = {pc4_q[31:28], instr_q[25:0], 2'b00};

    reg_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (WB_RegWrite),
        .wr_addr   (WB_WriteAddr),
        .wr_data   (WB_WriteData),
        .rd_addr_a (Rs_addr),
        .rd_addr_b (Rt_addr),
        .rd_data_a (Rs_data),
        .rd_data_b (Rt_data)
    );

endmodule

// File: tb/tb_if_id_decode.sv
module tb_if_id_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] IF_Instruction = '0;
    logic [31:0] IF_PC = '0;
    logic [31:0] IF_PC_plus4 = '0;
    logic        ID_Flush = 1'b0;
    logic        EX_MemRead = 1'b0;
    logic [4:0]  EX_Rt = '0;
    logic        WB_RegWrite = 1'b0;
    logic [4:0]  WB_WriteAddr = '0;
    logic [31:0] WB_WriteData = '0;
    logic [31:0] ID_Instruction, ID_PC, ID_PC_plus4;
    logic [4:0]  Rs_addr, Rt_addr, Rd_addr, Shamt;
    logic [31:0] Rs_data, Rt_data, Imm_ext, Branch_target, Jump_target;
    logic        PCWrite, IDEX_Bubble;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    if_id_decode dut (
        .clk(clk), .reset(reset),
        .IF_Instruction(IF_Instruction), .IF_PC(IF_PC), .IF_PC_plus4(IF_PC_plus4),
        .ID_Flush(ID_Flush), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
        .WB_RegWrite(WB_RegWrite), .WB_WriteAddr(WB_WriteAddr), .WB_WriteData(WB_WriteData),
        .ID_Instruction(ID_Instruction), .ID_PC(ID_PC), .ID_PC_plus4(ID_PC_plus4),
        .Rs_addr(Rs_addr), .Rt_addr(Rt_addr), .Rd_addr(Rd_addr), .Shamt(Shamt),
        .Rs_data(Rs_data), .Rt_data(Rt_data), .Imm_ext(Imm_ext),
        .Branch_target(Branch_target), .Jump_target(Jump_target),
        .PCWrite(PCWrite), .IDEX_Bubble(IDEX_Bubble)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_pc4   = '0;
    logic [31:0] m_regs [32];

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end

    function automatic int f_rs(input logic [31:0] w); return int'(w >> 21) % 32; endfunction
    function automatic int f_rt(input logic [31:0] w); return int'(w >> 16) % 32; endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (a == 0) return 32'h0;
        if (WB_RegWrite && int'(WB_WriteAddr) == a) return WB_WriteData;
        return m_regs[a];
    endfunction

    function automatic bit exp_stall();
        int rt_ex;
        rt_ex = int'(EX_Rt);
        return EX_MemRead && rt_ex != 0 && (rt_ex == f_rs(m_instr) || rt_ex == f_rt(m_instr));
    endfunction

    function automatic logic [31:0] exp_imm();
        int op;
        logic [31:0] lo;
        logic signed [31:0] s;
        op = int'(m_instr >> 26);
        lo = m_instr & 32'h0000FFFF;
        s  = $signed({{16{m_instr[15]}}, m_instr[15:0]});
        if (op == 12 || op == 13 || op == 14) return lo;
        if (op == 15) return lo * 65536;
        return s;
    endfunction

    function automatic logic [31:0] exp_branch();
        logic signed [31:0] s;
        s = $signed({{16{m_instr[15]}}, m_instr[15:0]});
        return m_pc4 + s * 4;
    endfunction

    function automatic logic [31:0] exp_jump();
        return (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_instr = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            bit st;
            st = exp_stall();
            if (WB_RegWrite && WB_WriteAddr != 0) m_regs[WB_WriteAddr] = WB_WriteData;
            if (ID_Flush) begin
                m_instr = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0;
            end else if (!st) begin
                m_instr = IF_Instruction; m_pc = IF_PC; m_pc4 = IF_PC_plus4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_instr",  ID_Instruction, m_instr);
            chk("m_pc",     ID_PC,          m_pc);
            chk("m_pc4",    ID_PC_plus4,    m_pc4);
            chk("m_rs",     32'(Rs_addr),   32'(f_rs(m_instr)));
            chk("m_rt",     32'(Rt_addr),   32'(f_rt(m_instr)));
            chk("m_rd",     32'(Rd_addr),   (m_instr >> 11) & 32'h1F);
            chk("m_shamt",  32'(Shamt),     (m_instr >> 6) & 32'h1F);
            chk("m_rsdata", Rs_data,        exp_read(f_rs(m_instr)));
            chk("m_rtdata", Rt_data,        exp_read(f_rt(m_instr)));
            chk("m_imm",    Imm_ext,        exp_imm());
            chk("m_btgt",   Branch_target,  exp_branch());
            chk("m_jtgt",   Jump_target,    exp_jump());
            chk("m_pcwr",   32'(PCWrite),   32'(!exp_stall()));
            chk("m_bubble", 32'(IDEX_Bubble), 32'(exp_stall()));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_if(input logic [31:0] ins, input logic [31:0] pc);
        IF_Instruction = ins; IF_PC = pc; IF_PC_plus4 = pc + 32'd4;
        edge_step();
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        WB_RegWrite = 1'b1; WB_WriteAddr = a; WB_WriteData = d;
        edge_step();
        WB_RegWrite = 1'b0;
    endtask

    initial begin
        #8;
        check_en = 1'b1;
        chk("rst_instr",  ID_Instruction, 32'h0);
        chk("rst_pcwr",   32'(PCWrite), 32'd1);
        chk("rst_bubble", 32'(IDEX_Bubble), 32'd0);
        #4 reset = 1'b1;
        edge_step();

        wb_write(5'd1, 32'h0000_0011);
        wb_write(5'd2, 32'h0000_0022);
        wb_write(5'd4, 32'h0000_0044);

        // lw $2, 4($1)
        load_if(32'h8C22_0004, 32'h0040_0000);
        chk("lw_instr", ID_Instruction, 32'h8C22_0004);
        chk("lw_rs",    32'(Rs_addr), 32'd1);
        chk("lw_rt",    32'(Rt_addr), 32'd2);
        chk("lw_imm",   Imm_ext, 32'h0000_0004);
        chk("lw_pcwr",  32'(PCWrite), 32'd1);
        chk("lw_rsdat", Rs_data, 32'h0000_0011);

        // add $3,$2,$4 with the lw now in EX
        load_if(32'h0044_1820, 32'h0040_0004);
        EX_MemRead = 1'b1; EX_Rt = 5'd2;
        #1;
        chk("lu_pcwr",   32'(PCWrite), 32'd0);
        chk("lu_bubble", 32'(IDEX_Bubble), 32'd1);
        IF_Instruction = 32'h2001_0007; IF_PC = 32'h0040_0008; IF_PC_plus4 = 32'h0040_000C;
        edge_step();
        chk("lu_hold", ID_Instruction, 32'h0044_1820);
        chk("lu_holdpc", ID_PC, 32'h0040_0004);
        EX_MemRead = 1'b0;
        #1;
        chk("lu_clear", 32'(PCWrite), 32'd1);
        edge_step();
        chk("lu_adv", ID_Instruction, 32'h2001_0007);

        // flush overrides stall
        load_if(32'h0044_1820, 32'h0040_0010);
        EX_MemRead = 1'b1; EX_Rt = 5'd4; ID_Flush = 1'b1;
        #1;
        chk("fl_stall", 32'(PCWrite), 32'd0);
        edge_step();
        chk("fl_instr", ID_Instruction, 32'h0);
        chk("fl_pc",    ID_PC, 32'h0);
        chk("fl_pcwr",  32'(PCWrite), 32'd1);
        ID_Flush = 1'b0; EX_MemRead = 1'b0; EX_Rt = 5'd0;

        // WB bypass on $5, then a write to $0
        load_if(32'h00A0_0000, 32'h0040_0020);
        WB_RegWrite = 1'b1; WB_WriteAddr = 5'd5; WB_WriteData = 32'hDEAD_BEEF;
        #1;
        chk("byp_same", Rs_data, 32'hDEAD_BEEF);
        edge_step();
        WB_RegWrite = 1'b0;
        #1;
        chk("byp_stored", Rs_data, 32'hDEAD_BEEF);
        load_if(32'h0005_0000, 32'h0040_0024);
        WB_RegWrite = 1'b1; WB_WriteAddr = 5'd0; WB_WriteData = 32'hFFFF_FFFF;
        #1;
        chk("r0_byp", Rs_data, 32'h0);
        chk("rt5",    Rt_data, 32'hDEAD_BEEF);
        edge_step();
        WB_RegWrite = 1'b0;
        #1;
        chk("r0_after", Rs_data, 32'h0);

        // immediates with ID_PC_plus4 = 0x00400004
        load_if(32'h3401_FFFF, 32'h0040_0000);
        chk("ori_imm",  Imm_ext, 32'h0000_FFFF);
        load_if(32'h2001_FFFF, 32'h0040_0000);
        chk("addi_imm", Imm_ext, 32'hFFFF_FFFF);
        load_if(32'h3C01_1234, 32'h0040_0000);
        chk("lui_imm",  Imm_ext, 32'h1234_0000);
        load_if(32'h1000_FFFF, 32'h0040_0000);
        chk("beq_tgt",  Branch_target, 32'h0040_0000);
        load_if(32'h0810_0000, 32'h0040_0000);
        chk("j_tgt",    Jump_target, 32'h0040_0000);
        load_if(32'h3001_8001, 32'h0040_0000);
        chk("andi_imm", Imm_ext, 32'h0000_8001);
        // branch target wrap-around
        load_if(32'h1000_0001, 32'hFFFF_FFF8);
        chk("beq_wrap", Branch_target, 32'h0000_0000);

        // reset asserted mid-stall
        load_if(32'h0044_1820, 32'h0040_0030);
        EX_MemRead = 1'b1; EX_Rt = 5'd2;
        #1;
        chk("rs_stall", 32'(PCWrite), 32'd0);
        reset = 1'b0;
        #1;
        chk("rs_instr",  ID_Instruction, 32'h0);
        chk("rs_pcwr",   32'(PCWrite), 32'd1);
        chk("rs_bubble", 32'(IDEX_Bubble), 32'd0);
        chk("rs_rsdata", Rs_data, 32'h0);
        EX_MemRead = 1'b0; EX_Rt = 5'd0;
        edge_step();
        reset = 1'b1;
        load_if(32'h0044_1820, 32'h0040_0040);
        chk("rs_r2clr", Rs_data, 32'h0);
        chk("rs_r4clr", Rt_data, 32'h0);
        edge_step();

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_decode.md
Name: if_id_decode

Overview:
- Stage directly downstream of instruction fetch in the 5-stage MIPS pipeline.
- Captures the fetched Instruction, PC and PC+4 into the IF/ID pipeline register.
- Reads the 32x32 register file, with write-before-read bypass from WB, and computes the immediate, branch-target and jump-target fields.
- Detects load-use hazards and generates the stall/bubble controls that hold PC and IF/ID.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register-file address width; 2**REG_AW registers.
- NOP, 32'h00000000, instruction word loaded on flush or reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- IF_Instruction  in  32  instruction from fetch; already zeroed by fetch on its flush.
- IF_PC  in  32  PC of that instruction.
- IF_PC_plus4  in  32  PC+4 from fetch.
- ID_Flush  in  1  exception/branch flush; loads NOP into IF/ID.
- EX_MemRead  in  1  instruction currently in ID/EX is a load.
- EX_Rt  in  5  destination register of that load.
- WB_RegWrite  in  1  write-back enable.
- WB_WriteAddr  in  5  write-back register address.
- WB_WriteData  in  32  write-back data.
- ID_Instruction  out  32  registered instruction.
- ID_PC  out  32  registered PC.
- ID_PC_plus4  out  32  registered PC+4.
- Rs_addr, Rt_addr, Rd_addr  out  5 each  fields [25:21], [20:16], [15:11].
- Shamt  out  5  field [10:6].
- Rs_data, Rt_data  out  32 each  register operands.
- Imm_ext  out  32  extended immediate.
- Branch_target  out  32  ID_PC_plus4 + (sext(imm) << 2).
- Jump_target  out  32  {ID_PC_plus4[31:28], instr[25:0], 2'b00}.
- PCWrite  out  1  0 holds the PC.
- IDEX_Bubble  out  1  1 forces NOP controls into ID/EX.

Behaviour:
- IF/ID register update priority, in order:
  - reset low: asynchronous clear; instruction = NOP, PC = 0, PC+4 = 0.
  - ID_Flush: load NOP, PC = 0, PC+4 = 0.
  - Stall: hold all three fields.
  - Otherwise: load IF_* inputs.
- Flush overrides stall when both are asserted in the same cycle.
- Hazard detection (combinational from IF/ID contents and EX inputs):
  - Stall = EX_MemRead && EX_Rt != 0 && (EX_Rt == Rs_addr || EX_Rt == Rt_addr).
  - PCWrite = ~Stall; IDEX_Bubble = Stall.
  - Exactly one stall cycle per load-use: the next cycle the load has left ID/EX, so EX_MemRead is no longer set for the same Rt.
- Register file:
  - 32 registers, asynchronous clear to 0 on reset.
  - Written on posedge clk when WB_RegWrite && WB_WriteAddr != 0.
  - Register $0 always reads 0; writes to it are ignored.
- Read ports are combinational. Bypass: if WB_RegWrite && WB_WriteAddr != 0 && WB_WriteAddr == read address, the port returns WB_WriteData in that same cycle.
- Imm_ext:
  - Zero-extended for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori).
  - {imm, 16'h0} for 0x0F (lui).
  - Sign-extended otherwise.
- Branch_target uses 32-bit modulo addition; wrap-around is permitted and not flagged.
- All outputs depend only on IF/ID contents and inputs. After reset, all outputs derive from NOP/0, giving PCWrite = 1 and IDEX_Bubble = 0.
- Reset asserted mid-stall: state clears immediately and the stall drops in the same cycle.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_ANDI, OP_ORI, OP_XORI, OP_LUI.
  - NOP word.
  - register-index constant REG_ZERO.
- One sub-module: reg_file (32x32, two read ports, one write port, $0 hardwired to zero, WB bypass).
- Hazard logic and immediate/target decode remain inline.

Test Plan:
- Reset release, then IF_Instruction = 0x8C220004 (lw) → after the next edge ID_Instruction = 0x8C220004, Rs_addr = 1, Rt_addr = 2, Imm_ext = 0x00000004, PCWrite = 1.
- Load-use: EX_MemRead = 1, EX_Rt = 2, ID holds add $3,$2,$4 (0x00441820) → PCWrite = 0 and IDEX_Bubble = 1 for one cycle; ID_Instruction unchanged across that edge.
- ID_Flush = 1 together with the stall condition → ID_Instruction = 0 and ID_PC = 0 after the edge; the stall clears.
- WB bypass: WB writes $5 = 0xDEADBEEF while ID reads $5 → Rs_data = 0xDEADBEEF in the same cycle. A write to $0 → Rs_data for $0 reads 0.
- Immediates with ID_PC_plus4 = 0x00400004:
  - ori imm 0xFFFF → Imm_ext = 0x0000FFFF.
  - addi imm 0xFFFF → Imm_ext = 0xFFFFFFFF.
  - lui 0x1234 → Imm_ext = 0x12340000.
  - beq imm 0xFFFF → Branch_target = 0x00400000.
- Reset low mid-stall → all registers read 0 asynchronously and PCWrite = 1 before the next clock edge.
